// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, FSM states, helpers.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SRA = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  // Opcodes 110 and 111 have no ALU function.
  function automatic logic is_undef_op(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the arbiter; shift amount is the full 32-bit B.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALUOp,
  output logic [DATA_W-1:0] C
);

  // Operation decode; undefined opcodes yield zero.
  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = A >> B;
      ALU_SRA: C = $signed(A) >>> B;
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  state_e              state;
  state_e              state_next;
  logic                prio;
  logic                owner;
  logic                grant;
  logic                accept;
  logic                rsp_done;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [2:0]          op_c;
  logic [DATA_W-1:0]   res;
  logic                err;
  logic [DATA_W-1:0]   alu_c;

  alu u_alu (
    .A     (op_a),
    .B     (op_b),
    .ALUOp (op_c),
    .C     (alu_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request selection, handshakes and next state.
  always_comb begin
    state_next = state;
    grant      = prio;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    busy       = 1'b1;

    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = !grant;
          req1_ready = grant;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        rsp_data   = res;
        rsp_err    = err;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, result capture and priority rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio  <= RR_INIT;
      owner <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        owner <= grant;
        op_a  <= grant ? req1_a  : req0_a;
        op_b  <= grant ? req1_b  : req0_b;
        op_c  <= grant ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        res <= alu_c;
        err <= is_undef_op(op_c);
      end
      if (rsp_done) begin
        prio <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus arbitration corner cases.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          r;
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] d;
    logic        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic drop(input int r);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
    check({tag, "_rsp0_valid"}, rsp0_valid, 0);
    check({tag, "_rsp1_valid"}, rsp1_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Wait for requester r to be granted; push its expected response.
  task automatic accept(input int r, input logic [31:0] d, input logic e, input bit release_valid);
    bit done = 1'b0;
    exp_t x;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("grant_r0", req0_ready, (r == 0) ? 1 : 0);
        check("grant_r1", req1_ready, (r == 1) ? 1 : 0);
        x.r = r; x.d = d; x.e = e;
        sb.push_back(x);
        done = 1'b1;
        @(posedge clk); #1;
        if (release_valid) drop(r);
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no grant expected grant to req%0d", r);
    end
  endtask

  // Wait for a response handshake and compare it against the scoreboard head.
  task automatic respond(input int exp_lat);
    bit done = 1'b0;
    int lat = 0;
    exp_t x;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      check("busy_during_op", busy, 1);
      check("no_accept_r0", req0_ready, 0);
      check("no_accept_r1", req1_ready, 0);
      if (rsp0_valid || rsp1_valid) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: got response expected none");
        end else begin
          x = sb.pop_front();
          check("rsp0_valid", rsp0_valid, (x.r == 0) ? 1 : 0);
          check("rsp1_valid", rsp1_valid, (x.r == 1) ? 1 : 0);
          check("rsp_data", rsp_data, x.d);
          check("rsp_err", rsp_err, x.e);
          if (exp_lat > 0) check("latency", lat, exp_lat);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: got no response expected one");
    end
  endtask

  initial begin
    vecs[0]  = '{0, 32'd5,        32'd3,        3'b000, 32'd8,        1'b0};
    vecs[1]  = '{1, 32'h80000000, 32'd4,        3'b101, 32'hF8000000, 1'b0};
    vecs[2]  = '{0, 32'h80000000, 32'd32,       3'b100, 32'h00000000, 1'b0};
    vecs[3]  = '{1, 32'h80000000, 32'd32,       3'b101, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{0, 32'd7,        32'd9,        3'b110, 32'h00000000, 1'b1};
    vecs[5]  = '{1, 32'hFFFFFFFF, 32'd1,        3'b000, 32'h00000000, 1'b0};
    vecs[6]  = '{0, 32'd10,       32'd4,        3'b001, 32'd6,        1'b0};
    vecs[7]  = '{1, 32'h000000F0, 32'h0000000F, 3'b011, 32'h000000FF, 1'b0};
    vecs[8]  = '{0, 32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h0000F000, 1'b0};
    vecs[9]  = '{1, 32'd3,        32'd5,        3'b111, 32'h00000000, 1'b1};
    vecs[10] = '{0, 32'd0,        32'd1,        3'b001, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{1, 32'h12345678, 32'd4,        3'b100, 32'h01234567, 1'b0};
    vecs[12] = '{0, 32'h7FFFFFFF, 32'd31,       3'b101, 32'h00000000, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
    @(posedge clk); #1;

    // Single-requester vectors, one at a time
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op);
      accept(vecs[i].r, vecs[i].d, vecs[i].e, 1'b1);
      respond(2);
    end

    // Ties with both requesters holding valid: priority alternates
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 32'd10, 32'd4, 3'b001);
    drive(1, 32'hF0, 32'h0F, 3'b011);
    accept(0, 32'd6, 1'b0, 1'b0);
    respond(2);
    accept(1, 32'hFF, 1'b0, 1'b0);
    respond(2);
    accept(0, 32'd6, 1'b0, 1'b0);
    respond(2);
    accept(1, 32'hFF, 1'b0, 1'b1);
    respond(2);
    accept(0, 32'd6, 1'b0, 1'b1);
    respond(2);

    // Response backpressure on requester 1 with requester 0 waiting
    rsp1_ready = 1'b0;
    drive(1, 32'd2, 32'd3, 3'b000);
    accept(1, 32'd5, 1'b0, 1'b1);
    drive(0, 32'd1, 32'd1, 3'b000);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp0_valid", rsp0_valid, 0);
      check("bp_rsp_data", rsp_data, 32'd5);
      check("bp_busy", busy, 1);
      check("bp_req0_ready", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    respond(0);
    accept(0, 32'd2, 1'b0, 1'b1);
    respond(2);

    // Reset while in RESP: operation discarded, priority back to RR_INIT
    rsp0_ready = 1'b0;
    drive(0, 32'd1, 32'd2, 3'b000);
    accept(0, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_rsp0_valid", rsp0_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rsp0_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    drive(0, 32'h11, 32'h22, 3'b000);
    drive(1, 32'd4, 32'd4, 3'b001);
    accept(0, 32'h33, 1'b0, 1'b1);
    respond(2);
    accept(1, 32'd0, 1'b0, 1'b1);
    respond(2);

    @(negedge clk);
    check("final_busy", busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
